// File: rtl/nonrestoring_divider.sv
// 16/8 signed non-restoring divider: magnitudes are divided one bit per
// cycle, then signs, remainder correction and range checks are applied.
module nonrestoring_divider (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [7:0]  divisor,
    output logic [7:0]  quotient,
    output logic [7:0]  remainder,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero,
    output logic        overflow
);

    typedef enum logic [1:0] {IDLE, CHECK, DIVIDE, FIX} state_t;

    state_t state, state_next;

    logic              sign_dvd;
    logic              sign_dvs;
    logic [15:0]       abs_dvd;
    logic [7:0]        abs_dvs;
    logic signed [9:0] rem_r;
    logic [7:0]        quo_r;
    logic [3:0]        count;
    logic              err_dz;
    logic              err_ov;

    logic [15:0]       abs_dvd_in;
    logic [7:0]        abs_dvs_in;
    logic              chk_dz;
    logic              chk_ov;
    logic signed [9:0] dvs_ext;
    logic signed [9:0] rem_shift;
    logic signed [9:0] rem_step;
    logic [7:0]        rem_fix;
    logic              q_neg;
    logic              q_range_ov;

    always_comb begin
        abs_dvd_in = dividend[15] ? 16'd0 - dividend : dividend;
        abs_dvs_in = divisor[7] ? 8'd0 - divisor : divisor;
        chk_dz     = (abs_dvs == 8'd0);
        chk_ov     = (abs_dvd[15:8] >= abs_dvs);
        dvs_ext    = {2'b00, abs_dvs};
        rem_shift  = {rem_r[8:0], quo_r[7]};
        rem_step   = rem_r[9] ? rem_shift + dvs_ext : rem_shift - dvs_ext;
        // final remainder lies in [-|D|, |D|); one add restores it
        rem_fix    = rem_r[9] ? rem_r[7:0] + abs_dvs : rem_r[7:0];
        q_neg      = sign_dvd ^ sign_dvs;
        q_range_ov = q_neg ? (quo_r > 8'd128) : (quo_r > 8'd127);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:   if (start) state_next = CHECK;
            CHECK:  state_next = (chk_dz || chk_ov) ? FIX : DIVIDE;
            DIVIDE: if (count == 4'd1) state_next = FIX;
            FIX:    state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sign_dvd    <= 1'b0;
            sign_dvs    <= 1'b0;
            abs_dvd     <= 16'd0;
            abs_dvs     <= 8'd0;
            rem_r       <= 10'sd0;
            quo_r       <= 8'd0;
            count       <= 4'd0;
            err_dz      <= 1'b0;
            err_ov      <= 1'b0;
            quotient    <= 8'd0;
            remainder   <= 8'd0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        sign_dvd <= dividend[15];
                        sign_dvs <= divisor[7];
                        abs_dvd  <= abs_dvd_in;
                        abs_dvs  <= abs_dvs_in;
                        err_dz   <= 1'b0;
                        err_ov   <= 1'b0;
                    end
                end
                CHECK: begin
                    if (chk_dz) begin
                        err_dz <= 1'b1;
                    end else if (chk_ov) begin
                        err_ov <= 1'b1;
                    end else begin
                        rem_r <= {2'b00, abs_dvd[15:8]};
                        quo_r <= abs_dvd[7:0];
                        count <= 4'd8;
                    end
                end
                DIVIDE: begin
                    rem_r <= rem_step;
                    quo_r <= {quo_r[6:0], ~rem_step[9]};
                    count <= count - 4'd1;
                end
                FIX: begin
                    done        <= 1'b1;
                    div_by_zero <= err_dz;
                    overflow    <= !err_dz && (err_ov || q_range_ov);
                    if (err_dz || err_ov || q_range_ov) begin
                        quotient  <= 8'd0;
                        remainder <= 8'd0;
                    end else begin
                        quotient  <= q_neg ? 8'd0 - quo_r : quo_r;
                        remainder <= sign_dvd ? 8'd0 - rem_fix : rem_fix;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nonrestoring_divider.sv
// Randomised and directed checks of nonrestoring_divider against an
// integer-arithmetic model of truncating signed division.
module tb_nonrestoring_divider;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic [7:0]  quotient;
    logic [7:0]  remainder;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic        overflow;

    int total = 0;
    int bad = 0;

    nonrestoring_divider dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void model(input int a, input int b,
                                  output logic [7:0] q, output logic [7:0] r,
                                  output bit dz, output bit ov, output int lat);
        int aa, ab, qi, ri;
        q = 8'd0;
        r = 8'd0;
        dz = 0;
        ov = 0;
        lat = 11;
        if (b == 0) begin
            dz = 1;
            lat = 3;
        end else begin
            aa = (a < 0) ? -a : a;
            ab = (b < 0) ? -b : b;
            if (aa / ab >= 256) begin
                ov = 1;
                lat = 3;
            end else begin
                qi = a / b;
                ri = a % b;
                if (qi > 127 || qi < -128) begin
                    ov = 1;
                end else begin
                    q = qi[7:0];
                    r = ri[7:0];
                end
            end
        end
    endfunction

    task automatic start_op(input logic signed [15:0] a,
                            input logic signed [7:0] b);
        dividend = a;
        divisor = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        dividend = 16'($urandom);
        divisor = 8'($urandom);
    endtask

    task automatic wait_result(input logic signed [15:0] a,
                               input logic signed [7:0] b, input bit noisy);
        logic [7:0] eq, er;
        bit edz, eov, got, busy_ok;
        int elat, edges;
        model(int'(a), int'(b), eq, er, edz, eov, elat);
        edges = 1;
        got = 0;
        busy_ok = (busy === 1'b1) && (done === 1'b0);
        while (edges < 20) begin
            if (noisy) begin
                start = 1'($urandom);
                dividend = 16'($urandom);
                divisor = 8'($urandom);
            end
            @(posedge clk);
            #1;
            edges++;
            if (done === 1'b1) begin
                got = 1;
                break;
            end
            if (busy !== 1'b1) busy_ok = 0;
        end
        start = 1'b0;
        chk("done_seen", 32'(got), 32'd1);
        chk("latency", edges, elat);
        chk("quotient", quotient, eq);
        chk("remainder", remainder, er);
        chk("div_by_zero", div_by_zero, edz);
        chk("overflow", overflow, eov);
        chk("busy_during", 32'(busy_ok), 32'd1);
        chk("busy_at_done", busy, 1'b0);
    endtask

    task automatic run_op(input logic signed [15:0] a,
                          input logic signed [7:0] b);
        @(negedge clk);
        start_op(a, b);
        wait_result(a, b, 0);
        @(posedge clk);
        #1;
        chk("done_width", done, 1'b0);
    endtask

    task automatic count_dones(input int cycles, input string tag);
        int n;
        n = 0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) n++;
        end
        chk(tag, n, 0);
    endtask

    logic signed [15:0] ra;
    logic signed [7:0]  rb;

    initial begin
        reset = 1'b1;
        start = 1'b0;
        dividend = 16'd0;
        divisor = 8'd0;
        #1;
        chk("reset_out", {quotient, remainder, busy, done, div_by_zero,
                          overflow}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        run_op(16'sd100, 8'sd7);
        run_op(-16'sd100, 8'sd7);
        run_op(16'sd100, -8'sd7);
        run_op(-16'sd100, -8'sd7);
        run_op(16'sd16384, -8'sd128);
        run_op(-16'sd16384, -8'sd128);
        run_op(16'sd100, 8'sd0);
        run_op(16'sh7FFF, 8'sd1);
        run_op(-16'sd32768, 8'sd1);
        run_op(16'sd0, -8'sd3);

        for (int i = 0; i < 150; i++) begin
            ra = 16'($urandom);
            rb = 8'($urandom);
            if ($urandom_range(0, 1) == 1) ra = ra >>> 7;
            if ($urandom_range(0, 15) == 0) rb = 8'sd0;
            run_op(ra, rb);
        end

        @(negedge clk);
        start_op(-16'sd1000, 8'sd9);
        wait_result(-16'sd1000, 8'sd9, 1);
        count_dones(15, "extra_done");

        @(negedge clk);
        start_op(16'sd1234, -8'sd56);
        wait_result(16'sd1234, -8'sd56, 0);
        start_op(16'sd100, 8'sd7);
        wait_result(16'sd100, 8'sd7, 0);

        @(negedge clk);
        start_op(16'sd1000, 8'sd9);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("midop_reset", {quotient, remainder, busy, done, div_by_zero,
                            overflow}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        count_dones(15, "done_after_abort");
        run_op(16'sd50, 8'sd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nonrestoring_divider.md
NONRESTORING_DIVIDER -- requirements
Module: nonrestoring_divider

Interface
REQ-001 The block SHALL have no parameters; widths are fixed: dividend 16 b, divisor 8 b, quotient 8 b, remainder 8 b.
REQ-002 clk  input  1  clock; all state SHALL update on the rising edge only.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 dividend  input  16  signed two's-complement numerator; captured on the accepted start edge.
REQ-006 divisor  input  8  signed two's-complement denominator; captured on the accepted start edge.
REQ-007 quotient  output  8  signed result, registered.
REQ-008 remainder  output  8  signed result, registered.
REQ-009 busy  output  1  high from the cycle after the accepted start until the result cycle.
REQ-010 done  output  1  one-cycle result-valid pulse.
REQ-011 div_by_zero  output  1  error flag; valid when done=1.
REQ-012 overflow  output  1  error flag; valid when done=1.

Function
REQ-013 The block SHALL use four states: IDLE, CHECK, DIVIDE, FIX.
REQ-014 On an edge in IDLE with start=1, the block SHALL latch sign(dividend), sign(divisor), |dividend| (17-bit safe), and |divisor| (9-bit safe), then go to CHECK.
REQ-015 In CHECK with divisor=0, the block SHALL set err_dz and go to FIX.
REQ-016 In CHECK with |dividend|[15:8] >= |divisor| (unsigned quotient >255), the block SHALL set err_ov and go to FIX.
REQ-017 In CHECK with neither error, the block SHALL load partial remainder=|dividend|[15:8], load Q=|dividend|[7:0], set count=8, and go to DIVIDE.
REQ-018 DIVIDE SHALL run one non-restoring iteration per cycle: shift {R,Q} left one; R=R-|D| if R>=0, else R+|D|; the new Q[0] is the inverted sign of the new R; count decrements.
REQ-019 After the iteration that brings count to 0, the block SHALL go to FIX.
REQ-020 In FIX, if the final R<0, the block SHALL add |D| to R once to correct it.
REQ-021 In FIX, quotient SHALL be negated if the operand signs differ, and remainder SHALL take the sign of dividend (truncation toward zero).
REQ-022 In FIX, the block SHALL set overflow if the signed quotient magnitude is out of range: >127 when positive, >128 when negative.
REQ-023 On div_by_zero or overflow, quotient and remainder SHALL be 8'h00.
REQ-024 On the FIX edge, the block SHALL register quotient, remainder, and flags, pulse done for exactly one cycle, drop busy, and go to IDLE.
REQ-025 Latency, normal path: done SHALL be high in the cycle following the 11th rising edge, counting the start edge as the 1st (start edge → CHECK → 8 × DIVIDE → FIX).
REQ-026 Latency, error path: done SHALL be high after the 3rd edge (start edge → CHECK → FIX).
REQ-027 start SHALL be ignored while busy=1 or the state is CHECK.
REQ-028 start in the done cycle (state IDLE) SHALL be accepted.
REQ-029 quotient, remainder, div_by_zero, and overflow SHALL hold their values until the next FIX.
REQ-030 Operand changes after the start edge SHALL not affect the result.

Reset
REQ-031 While reset=1, the block SHALL force state=IDLE, count=0, and all internal registers to 0.
REQ-032 While reset=1, quotient=0, remainder=0, busy=0, done=0, div_by_zero=0, and overflow=0, regardless of clk.
REQ-033 Reset asserted mid-operation SHALL abort the division with no done pulse.
REQ-034 The first start after reset deasserts SHALL behave as from power-up.

Verification
REQ-035 Normal division: dividend=100, divisor=7 → quotient=8'h0E, remainder=8'h02, done one cycle exactly 11 edges after start, busy high in between.
REQ-036 Signed operands, all four sign combinations:
- -100/7 → quotient=8'hF2, remainder=8'hFE.
- 100/-7 → quotient=8'hF2, remainder=8'h02.
- -100/-7 → quotient=8'h0E, remainder=8'hFE.
REQ-037 Boundary: 16384/-128 → quotient=8'h80, remainder=0, overflow=0; -16384/-128 → overflow=1, quotient=0, remainder=0.
REQ-038 Errors: 100/0 → div_by_zero=1, overflow=0, done after 3 edges; 16'h7FFF/1 → overflow=1, done after 3 edges.
REQ-039 Back-to-back and ignored start: start pulsed repeatedly during busy → exactly one done, result of the first operands; start in the done cycle → second result 11 edges later.
REQ-040 Reset mid-operation: reset asserted during the 4th DIVIDE cycle → all outputs 0 immediately, no done; a fresh 50/5 afterwards → quotient=10, remainder=0.
